attack_inverse_search: RTL and testbench



---
 rtl/attack_inverse_search_pkg.sv | 38 +++
 rtl/attack_inverse_div.sv | 53 +++++
 rtl/attack_inverse_search.sv | 145 ++++++++++++++
 tb/tb_attack_inverse_search.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/attack_inverse_search_pkg.sv
// Shared definitions for the attack-curve inverse search: the attack shaping
// curve (one copy, also used by the forward interpolating table), the search
// FSM states, and the level/address saturation constants.
package attack_inverse_search_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        PREP   = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Levels at or above 127*64 lie beyond the last interpolation segment.
    localparam logic [12:0] LEVEL_MAX = 13'd8128;
    localparam logic [21:0] ADDR_SAT  = 22'h3FFF80;

    // Attack shaping curve, monotonic non-decreasing, 7-bit integer levels.
    localparam logic [6:0] AR_ADJUST [0:127] = '{
        7'd0,   7'd0,   7'd0,   7'd0,   7'd0,   7'd1,   7'd1,   7'd1,
        7'd1,   7'd1,   7'd2,   7'd2,   7'd2,   7'd2,   7'd3,   7'd3,
        7'd3,   7'd3,   7'd4,   7'd4,   7'd4,   7'd4,   7'd5,   7'd5,
        7'd5,   7'd6,   7'd6,   7'd6,   7'd7,   7'd7,   7'd7,   7'd8,
        7'd8,   7'd8,   7'd9,   7'd9,   7'd9,   7'd10,  7'd10,  7'd11,
        7'd11,  7'd11,  7'd12,  7'd12,  7'd13,  7'd13,  7'd14,  7'd14,
        7'd15,  7'd15,  7'd16,  7'd16,  7'd17,  7'd17,  7'd18,  7'd19,
        7'd19,  7'd20,  7'd20,  7'd21,  7'd22,  7'd22,  7'd23,  7'd24,
        7'd24,  7'd25,  7'd26,  7'd27,  7'd27,  7'd28,  7'd29,  7'd30,
        7'd31,  7'd32,  7'd33,  7'd34,  7'd35,  7'd36,  7'd37,  7'd38,
        7'd39,  7'd40,  7'd41,  7'd43,  7'd44,  7'd45,  7'd47,  7'd48,
        7'd50,  7'd51,  7'd53,  7'd54,  7'd56,  7'd58,  7'd59,  7'd61,
        7'd63,  7'd65,  7'd67,  7'd69,  7'd71,  7'd74,  7'd76,  7'd79,
        7'd81,  7'd83,  7'd85,  7'd87,  7'd89,  7'd91,  7'd93,  7'd95,
        7'd97,  7'd99,  7'd101, 7'd103, 7'd105, 7'd107, 7'd108, 7'd109,
        7'd110, 7'd111, 7'd112, 7'd113, 7'd114, 7'd115, 7'd117, 7'd127
    };

endpackage

// File: rtl/attack_inverse_div.sv
// Restoring divider: 8-bit quotient of i_num / i_den, one bit per i_step, MSB first.
// Latency: i_start loads, then 8 i_step cycles; o_last is high during the 8th step.
// No backpressure: the caller owns sequencing; clkena=0 freezes all state.
// Ports: clk/reset_n/clkena; i_start, i_step control; i_num (15b), i_den (7b) operands;
//        o_quo quotient register; o_last marks the final iteration.
// The caller guarantees i_num < 256*i_den, so 8 quotient bits always suffice.
// The numerator is 4*(lv - d1*64) < 256*den, which needs 15 bits for a 7-bit divisor.
module attack_inverse_div (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clkena,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [14:0] i_num,
    input  logic [6:0]  i_den,
    output logic [7:0]  o_quo,
    output logic        o_last
);

    logic [14:0] r_rem;
    logic [14:0] r_dv;     // divisor aligned to the current quotient bit
    logic [7:0]  r_quo;
    logic [2:0]  r_cnt;
    logic        w_fit;

    assign w_fit  = (r_rem >= r_dv);
    assign o_quo  = r_quo;
    assign o_last = (r_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem <= '0;
            r_dv  <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (clkena) begin
            if (i_start) begin
                r_rem <= i_num;
                r_dv  <= {1'b0, i_den, 7'd0};
                r_quo <= '0;
                r_cnt <= '0;
            end else if (i_step) begin
                if (w_fit) begin
                    r_rem <= r_rem - r_dv;
                end
                r_quo <= {r_quo[6:0], w_fit};
                r_dv  <= {1'b0, r_dv[14:1]};
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/attack_inverse_search.sv
// Inverse attack curve: finds the attack phase address whose interpolated level equals 'level'.
// Latency: valid rises exactly 17 clkena=1 cycles after the cycle that accepts start.
// Backpressure: start is taken only in IDLE; starts while busy are dropped, clkena=0 freezes all.
// Ports: clk, reset_n (async, active-low), clkena; start/level request;
//        busy while searching; valid + addr = {seg[6:0], w[7:0], 7'b0} result.
module attack_inverse_search
    import attack_inverse_search_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clkena,
    input  logic        start,
    input  logic [12:0] level,
    output logic        busy,
    output logic        valid,
    output logic [21:0] addr
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [12:0] r_lv;
    logic [6:0]  r_seg;
    logic [2:0]  r_bit;
    logic        r_busy;
    logic        r_valid;
    logic [21:0] r_addr;

    logic        w_accept;
    logic        w_div_start;
    logic        w_div_step;
    logic        w_done;
    logic        w_div_last;
    logic [7:0]  w_quo;

    // Bitwise search: try setting the current bit; the candidate must stay
    // within segments 0..126 so that seg+1 is always a valid curve index.
    logic [6:0]  w_cand;
    logic        w_take;
    assign w_cand = r_seg | (7'd1 << r_bit);
    assign w_take = (w_cand != 7'd127) && ({AR_ADJUST[w_cand], 6'd0} <= r_lv);

    // Interpolation operands for the chosen segment.
    logic [6:0]  w_d1;
    logic [6:0]  w_d2;
    logic [12:0] w_diff;
    logic [14:0] w_num;
    logic [6:0]  w_den;
    assign w_d1   = AR_ADJUST[r_seg];
    assign w_d2   = AR_ADJUST[r_seg + 7'd1];
    assign w_diff = r_lv - {w_d1, 6'd0};
    assign w_num  = {w_diff, 2'b00};
    assign w_den  = w_d2 - w_d1;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_div_start = 1'b0;
        w_div_step  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (r_bit == 3'd0) begin
                    w_state_nxt = PREP;
                end
            end
            PREP: begin
                w_div_start = 1'b1;
                w_state_nxt = DIV;
            end
            DIV: begin
                w_div_step = 1'b1;
                if (w_div_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else if (clkena) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lv    <= '0;
            r_seg   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (clkena) begin
            if (w_accept) begin
                r_lv    <= level;
                r_seg   <= '0;
                r_bit   <= 3'd6;
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
            end
            if (r_state == SEARCH) begin
                if (w_take) begin
                    r_seg <= w_cand;
                end
                r_bit <= r_bit - 3'd1;
            end
            if (w_done) begin
                // Past the last segment the search/divide ran only to keep latency fixed.
                r_addr  <= (r_lv >= LEVEL_MAX) ? ADDR_SAT : {r_seg, w_quo, 7'd0};
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    attack_inverse_div u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clkena  (clkena),
        .i_start (w_div_start),
        .i_step  (w_div_step),
        .i_num   (w_num),
        .i_den   (w_den),
        .o_quo   (w_quo),
        .o_last  (w_div_last)
    );

    assign busy  = r_busy;
    assign valid = r_valid;
    assign addr  = r_addr;

endmodule

// File: tb/tb_attack_inverse_search.sv
module tb_attack_inverse_search;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clkena;
    logic        start;
    logic [12:0] level;
    logic        busy;
    logic        valid;
    logic [21:0] addr;

    int n_checks = 0;
    int n_errors = 0;

    // Independent copy of the attack curve for the reference model.
    int tbl [0:127] = '{
          0,   0,   0,   0,   0,   1,   1,   1,
          1,   1,   2,   2,   2,   2,   3,   3,
          3,   3,   4,   4,   4,   4,   5,   5,
          5,   6,   6,   6,   7,   7,   7,   8,
          8,   8,   9,   9,   9,  10,  10,  11,
         11,  11,  12,  12,  13,  13,  14,  14,
         15,  15,  16,  16,  17,  17,  18,  19,
         19,  20,  20,  21,  22,  22,  23,  24,
         24,  25,  26,  27,  27,  28,  29,  30,
         31,  32,  33,  34,  35,  36,  37,  38,
         39,  40,  41,  43,  44,  45,  47,  48,
         50,  51,  53,  54,  56,  58,  59,  61,
         63,  65,  67,  69,  71,  74,  76,  79,
         81,  83,  85,  87,  89,  91,  93,  95,
         97,  99, 101, 103, 105, 107, 108, 109,
        110, 111, 112, 113, 114, 115, 117, 127
    };

    always #5 clk = ~clk;

    attack_inverse_search dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clkena  (clkena),
        .start   (start),
        .level   (level),
        .busy    (busy),
        .valid   (valid),
        .addr    (addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: linear search for the segment, integer division for the weight.
    function automatic logic [21:0] model_addr(input int lv);
        int   seg;
        int   w;
        logic [21:0] a;
        if (lv >= 8128) return 22'h3FFF80;
        seg = 0;
        for (int s = 0; s <= 126; s++) begin
            if (tbl[s] * 64 <= lv) seg = s;
        end
        w = (4 * (lv - tbl[seg] * 64)) / (tbl[seg + 1] - tbl[seg]);
        a = {seg[6:0], w[7:0], 7'd0};
        return a;
    endfunction

    // Forward interpolating table applied to the DUT's address.
    function automatic bit round_trip_ok(input int lv, input logic [21:0] a);
        int seg;
        int frac;
        int fwd;
        int d1;
        int d2;
        seg  = int'(a[21:15]);
        frac = int'(a[14:0]);
        if (seg > 126) return 1'b0;
        d1  = tbl[seg];
        d2  = tbl[seg + 1];
        fwd = d1 * 64 + (((d2 - d1) * frac) >>> 9);
        return (fwd <= lv) && (fwd > lv - d2 + d1 - 1);
    endfunction

    // One request from IDLE; returns the result and the number of enabled
    // cycles after the accepting cycle until valid is seen.
    task automatic do_req(input logic [12:0] lv, input bit rand_en, input bit poke,
                          output logic [21:0] got, output int ncyc);
        level  = lv;
        start  = 1'b1;
        clkena = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        ncyc = 0;
        for (int i = 0; i < 200 && !valid; i++) begin
            clkena = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            start  = poke && (i == 4);
            level  = start ? 13'd8191 : lv;
            @(posedge clk); #1;
            if (clkena) ncyc++;
        end
        start  = 1'b0;
        clkena = 1'b1;
        check("valid_seen", {31'd0, valid}, 32'd1);
        got = addr;
    endtask

    logic [12:0] dir_lv  [0:5] = '{13'd0, 13'd32, 13'd64, 13'd8127, 13'd8128, 13'd8191};
    logic [21:0] dir_exp [0:5] = '{22'h020000, 22'h024000, 22'h048000,
                                   22'h3F7F80, 22'h3FFF80, 22'h3FFF80};
    logic [12:0] rnd_lv  [0:2] = '{13'd32, 13'd4000, 13'd8127};

    initial begin
        logic [21:0] got;
        int          nc;

        reset_n = 1'b0;
        clkena  = 1'b0;
        start   = 1'b0;
        level   = '0;
        #12;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_addr",  {10'd0, addr},  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed levels including both sides of the saturation threshold.
        for (int k = 0; k < 6; k++) begin
            do_req(dir_lv[k], 1'b0, 1'b0, got, nc);
            check($sformatf("dir_addr_%0d", dir_lv[k]), {10'd0, got}, {10'd0, dir_exp[k]});
            check($sformatf("dir_lat_%0d", dir_lv[k]), nc, 32'd17);
        end

        // clkena low freezes everything, including request acceptance.
        clkena = 1'b0;
        start  = 1'b1;
        level  = 13'd5;
        repeat (3) @(posedge clk);
        #1;
        check("frz_valid", {31'd0, valid}, 32'd1);
        check("frz_busy",  {31'd0, busy},  32'd0);
        check("frz_addr",  {10'd0, addr},  32'h3FFF80);
        start  = 1'b0;
        clkena = 1'b1;

        // Random clock enable: same result, latency counted in enabled cycles.
        for (int k = 0; k < 3; k++) begin
            do_req(rnd_lv[k], 1'b1, 1'b0, got, nc);
            check($sformatf("rnd_addr_%0d", rnd_lv[k]), {10'd0, got}, {10'd0, model_addr(int'(rnd_lv[k]))});
            check($sformatf("rnd_lat_%0d", rnd_lv[k]), nc, 32'd17);
        end

        // A start while busy must be dropped.
        do_req(13'd64, 1'b0, 1'b1, got, nc);
        check("poke_addr", {10'd0, got}, 32'h048000);
        check("poke_lat", nc, 32'd17);
        repeat (20) @(posedge clk);
        #1;
        check("poke_idle_busy",  {31'd0, busy},  32'd0);
        check("poke_idle_addr",  {10'd0, addr},  32'h048000);

        // Asynchronous reset in the third SEARCH cycle.
        level  = 13'd8127;
        start  = 1'b1;
        clkena = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",  {31'd0, busy},  32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_addr",  {10'd0, addr},  32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(13'd32, 1'b0, 1'b0, got, nc);
        check("post_rst_addr", {10'd0, got}, 32'h024000);
        check("post_rst_lat", nc, 32'd17);

        // Back-to-back sweep over the level range against the reference model.
        for (int lv = 0; lv < 8192; lv += 3) begin
            do_req(13'(lv), 1'b0, 1'b0, got, nc);
            check($sformatf("sweep_addr_%0d", lv), {10'd0, got}, {10'd0, model_addr(lv)});
            if (lv < 8128) begin
                check($sformatf("sweep_rt_%0d", lv), {31'd0, round_trip_ok(lv, got)}, 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
